// File: rtl/lut4_cfg_ctrl.sv
// Four-slot LUT4 evaluator with a serial reconfiguration controller.
// A new truth table is shifted through a working register before being committed to its slot.
module lut4_cfg_ctrl #(
    parameter logic [15:0] INIT0 = 16'h0000,
    parameter logic [15:0] INIT1 = 16'h0000,
    parameter logic [15:0] INIT2 = 16'h0000,
    parameter logic [15:0] INIT3 = 16'h0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [1:0]  CFG_SLOT,
    input  logic [15:0] CFG_DATA,
    input  logic [1:0]  EV_SEL,
    input  logic [3:0]  EV_I,
    output logic        EV_O,
    output logic        CDO,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0][15:0] INIT_TBL = {INIT3, INIT2, INIT1, INIT0};

    state_t            state_reg;
    state_t            state_next;
    logic [15:0]       s_reg;
    logic [15:0]       w_reg;
    logic [1:0]        slot_reg;
    logic [3:0]        cnt_reg;
    logic              ev_reg;
    logic [3:0][15:0]  tbl;
    logic              accept;
    logic              commit_en;
    logic              ready_int;

    // Next-state and status outputs. Every output is forced low while reset is held.
    always_comb begin
        state_next = state_reg;
        ready_int  = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        commit_en  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (CFG_VALID) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                BUSY = 1'b1;
                if (cnt_reg == 4'd15) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                BUSY       = 1'b1;
                DONE       = 1'b1;
                commit_en  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        ready_int = ready_int & RSTN;
        BUSY      = BUSY & RSTN;
        DONE      = DONE & RSTN;
        commit_en = commit_en & RSTN;
    end

    assign CFG_READY = ready_int;
    assign accept    = ready_int & CFG_VALID;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Working registers: S feeds new bits MSB-first into W while W's old MSB leaves on CDO.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            s_reg    <= 16'h0000;
            w_reg    <= 16'h0000;
            slot_reg <= 2'd0;
            cnt_reg  <= 4'd0;
        end else if (accept) begin
            s_reg    <= CFG_DATA;
            w_reg    <= tbl[CFG_SLOT];
            slot_reg <= CFG_SLOT;
            cnt_reg  <= 4'd0;
        end else if (state_reg == ST_SHIFT) begin
            s_reg   <= {s_reg[14:0], 1'b0};
            w_reg   <= {w_reg[14:0], s_reg[15]};
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    // One register per slot; the slot under load keeps its old contents until COMMIT ends.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_slot
            logic [15:0] tbl_reg;
            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    tbl_reg <= INIT_TBL[gi];
                end else if (commit_en && (slot_reg == 2'(gi))) begin
                    tbl_reg <= w_reg;
                end
            end
            assign tbl[gi] = tbl_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ev_reg <= 1'b0;
        end else begin
            ev_reg <= tbl[EV_SEL][EV_I];
        end
    end

    assign EV_O = ev_reg & RSTN;
    assign CDO  = (state_reg != ST_IDLE) & w_reg[15] & RSTN;

endmodule

// File: tb/tb_lut4_cfg_ctrl.sv
// Self-checking bench for lut4_cfg_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against an age-based behavioural model.
module tb_lut4_cfg_ctrl;

    localparam logic [15:0] P_INIT0 = 16'hFFFF;
    localparam logic [15:0] P_INIT1 = 16'h0000;
    localparam logic [15:0] P_INIT2 = 16'h8000;
    localparam logic [15:0] P_INIT3 = 16'hA5C3;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        CFG_VALID = 1'b0;
    logic [1:0]  CFG_SLOT = 2'd0;
    logic [15:0] CFG_DATA = 16'h0000;
    logic [1:0]  EV_SEL = 2'd0;
    logic [3:0]  EV_I = 4'd0;
    logic        CFG_READY;
    logic        EV_O;
    logic        CDO;
    logic        BUSY;
    logic        DONE;

    lut4_cfg_ctrl #(
        .INIT0(P_INIT0),
        .INIT1(P_INIT1),
        .INIT2(P_INIT2),
        .INIT3(P_INIT3)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .CFG_VALID(CFG_VALID),
        .CFG_READY(CFG_READY),
        .CFG_SLOT(CFG_SLOT),
        .CFG_DATA(CFG_DATA),
        .EV_SEL(EV_SEL),
        .EV_I(EV_I),
        .EV_O(EV_O),
        .CDO(CDO),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Model: age = cycles since acceptance (0 = idle, 1..16 shifting, 17 commit).
    logic [15:0] tbl_m [4];
    int          age_m = 0;
    logic [31:0] cat_m = 32'h0;
    logic [1:0]  slot_m = 2'd0;
    logic [15:0] data_m = 16'h0;
    logic        ev_m = 1'b0;
    int          cmp_count = 0;
    int          err_count = 0;
    int          cycle = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s cycle=%0d: got %0h, expected %0h", nm, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        tbl_m[0] = P_INIT0;
        tbl_m[1] = P_INIT1;
        tbl_m[2] = P_INIT2;
        tbl_m[3] = P_INIT3;
        age_m = 0;
        ev_m  = 1'b0;
        cat_m = 32'h0;
    endtask

    // Advance one clock: update the model at the rising edge, compare on the falling edge.
    task automatic tick();
        logic e_ready, e_busy, e_done, e_cdo, e_ev;
        @(posedge CLK);
        cycle++;
        if (!RSTN) begin
            if (age_m != 0) $display("reset abort at age %0d", age_m);
            model_reset();
        end else begin
            ev_m = tbl_m[EV_SEL][EV_I];
            if (age_m == 17) begin
                tbl_m[slot_m] = data_m;
                $display("commit slot=%0d data=%04h cycle=%0d", slot_m, data_m, cycle);
                age_m = 0;
            end else if (age_m > 0) begin
                age_m++;
            end else if (CFG_VALID) begin
                cat_m  = {tbl_m[CFG_SLOT], CFG_DATA};
                slot_m = CFG_SLOT;
                data_m = CFG_DATA;
                age_m  = 1;
                $display("accept slot=%0d data=%04h cycle=%0d", CFG_SLOT, CFG_DATA, cycle);
            end
        end
        @(negedge CLK);
        e_ready = RSTN && (age_m == 0);
        e_busy  = RSTN && (age_m != 0);
        e_done  = RSTN && (age_m == 17);
        e_cdo   = (RSTN && (age_m != 0)) ? cat_m[32 - age_m] : 1'b0;
        e_ev    = RSTN ? ev_m : 1'b0;
        chk("cfg_ready", {31'b0, CFG_READY}, {31'b0, e_ready});
        chk("busy",      {31'b0, BUSY},      {31'b0, e_busy});
        chk("done",      {31'b0, DONE},      {31'b0, e_done});
        chk("cdo",       {31'b0, CDO},       {31'b0, e_cdo});
        chk("ev_o",      {31'b0, EV_O},      {31'b0, e_ev});
    endtask

    initial begin
        logic [15:0] pat;
        int first, second, low_cnt, done_seen;
        model_reset();

        // Reset and initial tables
        RSTN = 1'b0;
        @(negedge CLK);
        tick();
        tick();
        chk("rst_ready_low", {31'b0, CFG_READY}, 32'd0);
        chk("rst_busy_low", {31'b0, BUSY}, 32'd0);
        RSTN = 1'b1;
        #1;
        chk("ready_after_release", {31'b0, CFG_READY}, 32'd1);
        EV_SEL = 2'd2;
        EV_I   = 4'hF;
        tick();
        chk("init2_addrF", {31'b0, EV_O}, 32'd1);
        EV_I = 4'hE;
        tick();
        chk("init2_addrE", {31'b0, EV_O}, 32'd0);

        // Load slot 1 with 6996; data changes right after acceptance
        CFG_VALID = 1'b1;
        CFG_SLOT  = 2'd1;
        CFG_DATA  = 16'h6996;
        EV_SEL    = 2'd1;
        EV_I      = 4'h1;
        tick();
        CFG_VALID = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            chk("ld1_busy", {31'b0, BUSY}, (k <= 17) ? 32'd1 : 32'd0);
            chk("ld1_done", {31'b0, DONE}, (k == 17) ? 32'd1 : 32'd0);
            chk("ld1_ev_old_new", {31'b0, EV_O}, (k >= 19) ? 32'd1 : 32'd0);
            if (k == 1) CFG_DATA = 16'h1234;
            tick();
        end
        pat = 16'h6996;
        for (int i = 0; i < 16; i++) begin
            EV_I = 4'(i);
            tick();
            chk("slot1_sweep", {31'b0, EV_O}, {31'b0, pat[i]});
        end

        // Slot 0 FFFF -> 0000: CDO high throughout SHIFT
        CFG_VALID = 1'b1;
        CFG_SLOT  = 2'd0;
        CFG_DATA  = 16'h0000;
        tick();
        CFG_VALID = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("cdo_ones", {31'b0, CDO}, 32'd1);
            tick();
        end
        tick();
        EV_SEL = 2'd0;
        EV_I   = 4'h5;
        tick();
        chk("slot0_cleared", {31'b0, EV_O}, 32'd0);

        // CFG_VALID held through two requests
        first = -1;
        second = -1;
        low_cnt = 0;
        CFG_VALID = 1'b1;
        CFG_SLOT  = 2'd3;
        CFG_DATA  = 16'h1111;
        for (int n = 0; n < 60; n++) begin
            if (CFG_READY === 1'b1) begin
                if (first < 0) first = n;
                else second = n;
            end else if (first >= 0) begin
                low_cnt++;
            end
            tick();
            if (second >= 0) break;
            if (first >= 0) CFG_DATA = 16'h2222;
        end
        CFG_VALID = 1'b0;
        chk("accept_spacing", second - first, 32'd18);
        chk("ready_low_between", low_cnt, 32'd17);
        for (int n = 0; n < 18; n++) tick();

        // Reset at SHIFT counter 7 aborts the load
        CFG_VALID = 1'b1;
        CFG_SLOT  = 2'd2;
        CFG_DATA  = 16'h0000;
        tick();
        CFG_VALID = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        chk("busy_mid_shift", {31'b0, BUSY}, 32'd1);
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        #1;
        chk("ready_after_abort", {31'b0, CFG_READY}, 32'd1);
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (DONE === 1'b1) done_seen++;
        end
        chk("no_done_after_abort", done_seen, 32'd0);
        EV_SEL = 2'd2;
        EV_I   = 4'hF;
        tick();
        chk("slot2_reverted", {31'b0, EV_O}, 32'd1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            RSTN      = ($urandom_range(0, 399) != 0);
            CFG_VALID = ($urandom_range(0, 5) == 0);
            CFG_SLOT  = 2'($urandom);
            CFG_DATA  = 16'($urandom);
            EV_SEL    = 2'($urandom);
            EV_I      = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/lut4_cfg_ctrl.md
LUT4_CFG_CTRL -- requirements
Module: lut4_cfg_ctrl

Interface
REQ-001 SHALL have parameter INIT0, default 16'h0000, reset truth table of slot 0.
REQ-002 SHALL have parameter INIT1, default 16'h0000, reset truth table of slot 1.
REQ-003 SHALL have parameter INIT2, default 16'h0000, reset truth table of slot 2.
REQ-004 SHALL have parameter INIT3, default 16'h0000, reset truth table of slot 3.
REQ-005 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port RSTN  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port CFG_VALID  input  1  config request valid.
REQ-008 SHALL have port CFG_READY  output  1  controller accepts a config request.
REQ-009 SHALL have port CFG_SLOT  input  2  target slot index.
REQ-010 SHALL have port CFG_DATA  input  16  new truth table, bit k = output for address k.
REQ-011 SHALL have port EV_SEL  input  2  slot selected for evaluation.
REQ-012 SHALL have port EV_I  input  4  LUT address {I3,I2,I1,I0}.
REQ-013 SHALL have port EV_O  output  1  registered LUT result.
REQ-014 SHALL have port CDO  output  1  serial bit shifted out of the working register.
REQ-015 SHALL have port BUSY  output  1  load sequence in progress.
REQ-016 SHALL have port DONE  output  1  one-cycle commit pulse.

Function
REQ-017 SHALL hold four 16-bit truth-table registers TBL[0..3].
REQ-018 SHALL produce EV_O(t+1) = TBL[EV_SEL(t)][EV_I(t)]; latency 1 cycle, every cycle, independent of config state.
REQ-019 SHALL implement FSM states IDLE, SHIFT, COMMIT.
REQ-020 SHALL drive CFG_READY = 1 only in IDLE; BUSY = 1 in SHIFT and COMMIT.
REQ-021 SHALL accept a request on a cycle with CFG_VALID & CFG_READY: latch S <= CFG_DATA, slot <= CFG_SLOT, W <= TBL[CFG_SLOT], counter <= 0, go to SHIFT.
REQ-022 SHALL ignore CFG_DATA/CFG_SLOT changes after acceptance.
REQ-023 SHALL in each SHIFT cycle do W <= {W[14:0], S[15]}, S <= {S[14:0],1'b0}, counter += 1 (4-bit).
REQ-024 SHALL drive CDO = W[15] registered (bit being shifted out); CDO = 0 in IDLE.
REQ-025 SHALL leave SHIFT after exactly 16 cycles (counter wraps 15->0), entering COMMIT with W == accepted CFG_DATA.
REQ-026 SHALL in COMMIT assert DONE for exactly that cycle, write TBL[slot] <= W at its end, return to IDLE.
REQ-027 SHALL leave TBL[slot] unchanged until COMMIT end; evaluations of the slot under load return old contents through the COMMIT cycle.
REQ-028 SHALL give accept-to-DONE = 17 cycles; minimum accept-to-accept spacing = 18 cycles.
REQ-029 SHALL not accept CFG_VALID held high during SHIFT/COMMIT; it is accepted on the first IDLE cycle.
REQ-030 SHALL let EV_SEL equal the loading slot without stall or error.

Reset
REQ-031 SHALL on RSTN = 0 at a clock edge load TBL[n] <= INITn, state <= IDLE, counter <= 0, S,W <= 0.
REQ-032 SHALL hold EV_O = 0, CDO = 0, DONE = 0, BUSY = 0, CFG_READY = 0 while RSTN = 0; CFG_READY = 1 on first cycle after release.
REQ-033 SHALL abort a load on reset mid-SHIFT or in COMMIT: no DONE, no table write; tables revert to INITn.

Verification
REQ-034 SHALL cover: reset with INIT2=16'h8000, EV_SEL=2, EV_I=4'hF -> EV_O=1 next cycle; EV_I=4'hE -> EV_O=0.
REQ-035 SHALL cover: load slot 1 with 16'h6996 at cycle T -> BUSY T+1..T+17, DONE only at T+17, EV_SEL=1/EV_I=4'h1 gives old value through T+18 sample and 1 from T+19.
REQ-036 SHALL cover: slot 0 = 16'hFFFF, load 16'h0000 -> CDO = 1 for 16 SHIFT cycles, then table reads 0.
REQ-037 SHALL cover: CFG_VALID held high for two requests -> second accepted exactly 18 cycles after first, CFG_READY low between.
REQ-038 SHALL cover: RSTN low at SHIFT counter 7 -> no DONE, target slot reads INITn, CFG_READY = 1 after release.
REQ-039 SHALL cover: CFG_DATA changed on cycle after accept -> committed table equals value at accept.
